// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default sizes for the parametrised register file
package reg_file_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// rtl/reg_file_clear_fsm.sv - sequential clear engine: walks every entry writing zero
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // clr_req is only honoured in RUN; a clear in progress never restarts
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = '0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_idx_nxt = '0;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        busy     = (r_state == ST_CLEAR);
        clr_we   = (r_state == ST_CLEAR);
        clr_addr = r_clr_idx;
    end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - 2-read/1-write register file with bypass, zero register and clear engine
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_drop;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_zero;
    logic              w_wr_ok;
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];

    reg_file_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // w_wr_ok is the single notion of "this write lands", shared by storage and bypass
    assign w_wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_wr_ok   = wr_en && !w_busy && !w_wr_zero;

    // Storage is deliberately not reset; the clear engine zeroes it after every reset
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_busy && wr_en;
        end
    end

    assign w_rd_addr[0] = rd_addr1;
    assign w_rd_addr[1] = rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_data[p] = r_mem[w_rd_addr[p]];
            if (w_busy) begin
                w_rd_data[p] = '0;
            end else if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
                w_rd_data[p] = '0;
            end else if ((BYPASS != 0) && w_wr_ok && (wr_addr == w_rd_addr[p])) begin
                w_rd_data[p] = wr_data;
            end
        end
    end

    assign rd_data1 = w_rd_data[0];
    assign rd_data2 = w_rd_data[1];
    assign busy     = w_busy;
    assign wr_drop  = r_wr_drop;

endmodule
